ipdc_win_ctrl: RTL and testbench

- Parametrised successor to the fixed 8x8 IPDC display controller.
- Stores one IMG_W x IMG_H image of PIX_W-bit pixels in an internal buffer and keeps a display window with a variable origin and a variable size.
- Each op moves or rescales the window, then streams the window pixels in raster order on a valid-only output.
- Sits between the pixel loader and the display stage.

---
 rtl/ipdc_pkg.sv | 31 +++
 rtl/ipdc_img_buf.sv | 32 +++
 rtl/ipdc_win_ctrl.sv | 178 +++++++++++++++++
 tb/tb_ipdc_win_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ipdc_pkg.sv
// Shared constants and types for the windowed image display controller.
package ipdc_pkg;

  // Op codes carried on i_op_mode
  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_RIGHT = 3'd1;
  localparam logic [2:0] OP_LEFT  = 3'd2;
  localparam logic [2:0] OP_UP    = 3'd3;
  localparam logic [2:0] OP_DOWN  = 3'd4;
  localparam logic [2:0] OP_SDN   = 3'd5;
  localparam logic [2:0] OP_SUP   = 3'd6;
  localparam logic [2:0] OP_SHOW  = 3'd7;

  // Controller states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    UPD  = 2'd2,
    OUT  = 2'd3
  } state_e;

  // Default RGB 8/8/8 pixel
  localparam int unsigned DEF_PIX_W = 24;
  typedef logic [DEF_PIX_W-1:0] rgb_t;

  // Index width that never collapses to zero bits
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ipdc_img_buf.sv
// Image buffer: register array, one synchronous write port and one
// combinational read port, cleared synchronously on reset.
module ipdc_img_buf
  import ipdc_pkg::*;
#(
  parameter int PIX_W = DEF_PIX_W,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [PIX_W-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [PIX_W-1:0] o_rdata
);

  logic [PIX_W-1:0] mem_q [DEPTH];

  // Clear every entry on reset, otherwise write one pixel per enabled edge
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/ipdc_win_ctrl.sv
// Windowed display controller: holds an image, moves/rescales a square
// window over it and streams the window pixels in raster order.
module ipdc_win_ctrl
  import ipdc_pkg::*;
#(
  parameter int PIX_W   = 24,
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 8,
  parameter int WIN_MAX = 4,
  parameter int WIN_MIN = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_op_valid,
  input  logic [2:0]       i_op_mode,
  output logic             o_op_ready,
  input  logic             i_in_valid,
  input  logic [PIX_W-1:0] i_in_data,
  output logic             o_in_ready,
  output logic             o_out_valid,
  output logic [PIX_W-1:0] o_out_data
);

  localparam int CW    = clog2_min1(IMG_W);    // column / origin-col width
  localparam int RW    = clog2_min1(IMG_H);    // row / origin-row width
  localparam int AW    = CW + RW;              // buffer address width
  localparam int DEPTH = IMG_W * IMG_H;
  localparam int KW    = clog2_min1(WIN_MAX);  // in-window offset width
  localparam int WW    = $clog2(WIN_MAX) + 1;  // window edge holds WIN_MAX
  localparam int XW    = CW + 1;               // col clamp arithmetic width
  localparam int YW    = RW + 1;               // row clamp arithmetic width

  state_e           st_q, st_d;
  logic [2:0]       op_q;
  logic [RW-1:0]    row_q, row_d;
  logic [CW-1:0]    col_q, col_d;
  logic [WW-1:0]    win_q, win_d;
  logic [AW-1:0]    ld_cnt_q;
  logic [KW-1:0]    r_q, c_q;
  logic             fin_q;
  logic             out_valid_q;
  logic [PIX_W-1:0] out_data_q;

  logic             op_acc, ld_acc, ld_last;
  logic             row_last, col_last;
  logic [XW-1:0]    max_col, max_col_up;
  logic [YW-1:0]    max_row, max_row_up;
  logic [WW-1:0]    win_up;
  logic [RW-1:0]    rd_row;
  logic [CW-1:0]    rd_col;
  logic [AW-1:0]    raddr;
  logic [PIX_W-1:0] rdata;

  assign op_acc  = i_op_valid && (st_q == IDLE);
  assign ld_acc  = i_in_valid && (st_q == LOAD);
  assign ld_last = (ld_cnt_q == AW'(DEPTH - 1));

  // Largest legal origin for the current edge and for a doubled edge
  assign win_up     = (win_q < WW'(WIN_MAX)) ? (win_q << 1) : win_q;
  assign max_col    = XW'(IMG_W) - XW'(win_q);
  assign max_row    = YW'(IMG_H) - YW'(win_q);
  assign max_col_up = XW'(IMG_W) - XW'(win_up);
  assign max_row_up = YW'(IMG_H) - YW'(win_up);

  // Window geometry update: saturating moves/scales in UPD, home after a load
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    win_d = win_q;
    if (st_q == UPD) begin
      case (op_q)
        OP_RIGHT: if (XW'(col_q) < max_col) col_d = col_q + CW'(1);
        OP_LEFT:  if (col_q != '0)          col_d = col_q - CW'(1);
        OP_UP:    if (row_q != '0)          row_d = row_q - RW'(1);
        OP_DOWN:  if (YW'(row_q) < max_row) row_d = row_q + RW'(1);
        OP_SDN:   if (win_q > WW'(WIN_MIN)) win_d = win_q >> 1;
        OP_SUP: begin
          win_d = win_up;
          // a larger window may no longer fit at the old origin
          if (XW'(col_q) > max_col_up) col_d = CW'(max_col_up);
          if (YW'(row_q) > max_row_up) row_d = RW'(max_row_up);
        end
        default: ;
      endcase
    end else if (ld_acc && ld_last) begin
      row_d = '0;
      col_d = '0;
      win_d = WW'(WIN_MAX);
    end
  end

  // Next-state selection
  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE: if (op_acc) st_d = (i_op_mode == OP_LOAD) ? LOAD : UPD;
      LOAD: if (ld_acc && ld_last) st_d = IDLE;
      UPD:  st_d = OUT;
      OUT:  if (fin_q) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // Window-relative raster position mapped onto the row-major buffer
  assign col_last = (WW'(c_q) == win_q - WW'(1));
  assign row_last = (WW'(r_q) == win_q - WW'(1));
  assign rd_row   = row_q + RW'(r_q);
  assign rd_col   = col_q + CW'(c_q);
  assign raddr    = {rd_row, rd_col};

  ipdc_img_buf #(
    .PIX_W (PIX_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_buf (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (ld_acc),
    .i_waddr (ld_cnt_q),
    .i_wdata (i_in_data),
    .i_raddr (raddr),
    .o_rdata (rdata)
  );

  // FSM, geometry and load-counter registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st_q     <= IDLE;
      op_q     <= OP_SHOW;
      row_q    <= '0;
      col_q    <= '0;
      win_q    <= WW'(WIN_MAX);
      ld_cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      row_q <= row_d;
      col_q <= col_d;
      win_q <= win_d;
      if (op_acc) op_q <= i_op_mode;
      // wraps back to 0 after the last pixel, ready for the next load
      if (ld_acc) ld_cnt_q <= ld_last ? '0 : ld_cnt_q + AW'(1);
    end
  end

  // Output stream: one registered pixel per OUT cycle until the window is done
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q         <= '0;
      c_q         <= '0;
      fin_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (st_q == UPD) begin
      r_q         <= '0;
      c_q         <= '0;
      fin_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (st_q == OUT && !fin_q) begin
      out_valid_q <= 1'b1;
      out_data_q  <= rdata;
      if (col_last) begin
        c_q <= '0;
        if (row_last) fin_q <= 1'b1;
        else          r_q   <= r_q + KW'(1);
      end else begin
        c_q <= c_q + KW'(1);
      end
    end else begin
      out_valid_q <= 1'b0;
    end
  end

  assign o_op_ready  = (st_q == IDLE);
  assign o_in_ready  = (st_q == LOAD);
  assign o_out_valid = out_valid_q;
  assign o_out_data  = out_data_q;

endmodule

// File: tb/tb_ipdc_win_ctrl.sv
// Bench for ipdc_win_ctrl: directed vector table, reset/handshake corner
// sequences and random ops against a window model.
module tb_ipdc_win_ctrl;

  localparam int PIX_W   = 24;
  localparam int IMG_W   = 8;
  localparam int IMG_H   = 8;
  localparam int WIN_MAX = 4;
  localparam int WIN_MIN = 2;
  localparam int NPIX    = IMG_W * IMG_H;

  logic             clk = 1'b0;
  logic             rst;
  logic             op_valid;
  logic [2:0]       op_mode;
  logic             op_ready;
  logic             in_valid;
  logic [PIX_W-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [PIX_W-1:0] out_data;

  ipdc_win_ctrl #(
    .PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H),
    .WIN_MAX(WIN_MAX), .WIN_MIN(WIN_MIN)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_op_valid(op_valid), .i_op_mode(op_mode), .o_op_ready(op_ready),
    .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(in_ready),
    .o_out_valid(out_valid), .o_out_data(out_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Window model
  logic [PIX_W-1:0] mem [NPIX];
  int mrow, mcol, mwin;

  // Captured stream of the last op
  logic [PIX_W-1:0] got [$];
  int first_e, last_e, ready_e;

  typedef struct {
    int op;
    int n;
    int first;
    int last;
  } vec_t;
  vec_t tbl [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NPIX; i++) mem[i] = '0;
    mrow = 0; mcol = 0; mwin = WIN_MAX;
  endtask

  task automatic model_op(input int op);
    case (op)
      1: if (mcol < IMG_W - mwin) mcol++;
      2: if (mcol > 0) mcol--;
      3: if (mrow > 0) mrow--;
      4: if (mrow < IMG_H - mwin) mrow++;
      5: if (mwin > WIN_MIN) mwin = mwin / 2;
      6: begin
        if (mwin < WIN_MAX) mwin = mwin * 2;
        if (mcol > IMG_W - mwin) mcol = IMG_W - mwin;
        if (mrow > IMG_H - mwin) mrow = IMG_H - mwin;
      end
      default: ;
    endcase
  endtask

  function automatic logic [PIX_W-1:0] model_pix(input int k);
    return mem[(mrow + k / mwin) * IMG_W + mcol + k % mwin];
  endfunction

  // Issue one non-load op, capture its stream and check it against the model.
  // With hold set, i_op_valid stays high through OUT to probe the handshake.
  task automatic run_op(input int op, input bit hold, input string tag);
    int k;
    got.delete();
    first_e = -1; last_e = -1; ready_e = -1;
    @(negedge clk);
    chk({tag, " ready_before"}, op_ready, 1);
    op_valid = 1'b1;
    op_mode  = 3'(op);
    @(posedge clk); #1;
    if (!hold) op_valid = 1'b0;
    for (int e = 1; e <= WIN_MAX * WIN_MAX + 8; e++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        if (first_e < 0) first_e = e;
        last_e = e;
        got.push_back(out_data);
      end
      if (op_ready) begin
        ready_e  = e;
        op_valid = 1'b0;
        break;
      end
    end
    op_valid = 1'b0;
    model_op(op);
    k = mwin * mwin;
    chk({tag, " count"}, got.size(), k);
    chk({tag, " first_edge"}, first_e, 2);
    chk({tag, " last_edge"}, last_e, k + 1);
    chk({tag, " ready_edge"}, ready_e, k + 2);
    for (int i = 0; i < k; i++)
      chk($sformatf("%s pix%0d", tag, i), (i < got.size()) ? got[i] : 64'hDEAD, model_pix(i));
  endtask

  // Load a full image; optional random data and random i_in_valid gaps
  task automatic load_img(input bit rnd, input bit gaps, input string tag);
    int n = 0;
    int cyc = 0;
    bit early_drop = 0;
    bit out_seen = 0;
    logic [PIX_W-1:0] d;
    @(negedge clk);
    op_valid = 1'b1;
    op_mode  = 3'd0;
    @(posedge clk); #1;
    op_valid = 1'b0;
    chk({tag, " in_ready_start"}, in_ready, 1);
    while (n < NPIX && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
      end else begin
        d = rnd ? PIX_W'($urandom) : PIX_W'(n);
        in_valid = 1'b1;
        in_data  = d;
        mem[n]   = d;
        n++;
      end
      @(posedge clk); #1;
      if (out_valid) out_seen = 1;
      if (n < NPIX && !in_ready) early_drop = 1;
    end
    in_valid = 1'b0;
    chk({tag, " load_timeout"}, n, NPIX);
    chk({tag, " in_ready_held"}, early_drop, 0);
    chk({tag, " no_output"}, out_seen, 0);
    chk({tag, " in_ready_drop"}, in_ready, 0);
    chk({tag, " op_ready_after"}, op_ready, 1);
    mrow = 0; mcol = 0; mwin = WIN_MAX;
  endtask

  initial begin
    int extra;
    rst = 1'b1; op_valid = 1'b0; op_mode = '0; in_valid = 1'b0; in_data = '0;
    model_reset();

    // {op, pixel count, first pixel, last pixel} with image[i] = i, from (0,0) win 4
    tbl.push_back('{7,16,0,27});  tbl.push_back('{1,16,1,28});
    tbl.push_back('{2,16,0,27});  tbl.push_back('{2,16,0,27});
    tbl.push_back('{4,16,8,35});  tbl.push_back('{4,16,16,43});
    tbl.push_back('{4,16,24,51}); tbl.push_back('{4,16,32,59});
    tbl.push_back('{1,16,33,60}); tbl.push_back('{1,16,34,61});
    tbl.push_back('{1,16,35,62}); tbl.push_back('{1,16,36,63});
    tbl.push_back('{1,16,36,63}); tbl.push_back('{4,16,36,63});
    tbl.push_back('{5,4,36,45});
    tbl.push_back('{2,4,35,44});  tbl.push_back('{2,4,34,43});
    tbl.push_back('{2,4,33,42});
    tbl.push_back('{3,4,25,34});  tbl.push_back('{3,4,17,26});
    tbl.push_back('{3,4,9,18});   tbl.push_back('{3,4,1,10});
    tbl.push_back('{5,4,1,10});   tbl.push_back('{5,4,1,10});
    tbl.push_back('{4,4,9,18});   tbl.push_back('{4,4,17,26});
    tbl.push_back('{4,4,25,34});  tbl.push_back('{4,4,33,42});
    tbl.push_back('{4,4,41,50});  tbl.push_back('{4,4,49,58});
    tbl.push_back('{1,4,50,59});  tbl.push_back('{1,4,51,60});
    tbl.push_back('{1,4,52,61});  tbl.push_back('{1,4,53,62});
    tbl.push_back('{1,4,54,63});
    tbl.push_back('{6,16,36,63});

    repeat (3) @(posedge clk);
    #1;
    chk("reset op_ready", op_ready, 1);
    chk("reset in_ready", in_ready, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    @(negedge clk); rst = 1'b0;

    // Op on the cleared buffer before any load
    run_op(7, 0, "preload");

    load_img(0, 1, "load1");
    foreach (tbl[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      run_op(tbl[i].op, 0, t);
      chk({t, " tbl_n"}, got.size(), tbl[i].n);
      chk({t, " tbl_first"}, (got.size() > 0) ? got[0] : 64'hDEAD, tbl[i].first);
      chk({t, " tbl_last"}, (got.size() > 0) ? got[got.size()-1] : 64'hDEAD, tbl[i].last);
    end

    // Reset pulse while the 5th pixel is on the output
    @(negedge clk); op_valid = 1'b1; op_mode = 3'd7;
    @(posedge clk); #1; op_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_mid valid_before", out_valid, 1);
    chk("rst_mid pix4", out_data, model_pix(4));
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk("rst_mid out_valid", out_valid, 0);
    chk("rst_mid op_ready", op_ready, 1);
    chk("rst_mid in_ready", in_ready, 0);
    chk("rst_mid out_data", out_data, 0);
    model_reset();
    run_op(7, 0, "after_rst");
    chk("after_rst zero0", (got.size() > 0) ? got[0] : 64'hDEAD, 0);

    // Op request held through OUT must not start a second stream
    load_img(0, 0, "load2");
    run_op(7, 1, "hold");
    extra = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) extra++;
    end
    chk("hold extra_stream", extra, 0);
    chk("hold op_ready", op_ready, 1);

    // Random image and random ops against the model
    load_img(1, 1, "load_rnd");
    for (int i = 0; i < 60; i++)
      run_op($urandom_range(1, 7), bit'($urandom_range(0, 1)), $sformatf("rnd%0d", i));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
